// File: rtl/reg_transfer_file.sv
// Register file of NUM_REGS words sharing one internal transfer bus.
// A small command FSM sequences LOAD, MOVE, SWAP and CLEAR behind a valid/ready handshake.
module reg_transfer_file #(
  parameter int WORD_LENGTH = 8,
  parameter int NUM_REGS    = 4,
  localparam int ADDR_W     = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [ADDR_W-1:0]      cmd_src,
  input  logic [ADDR_W-1:0]      cmd_dst,
  input  logic [WORD_LENGTH-1:0] cmd_data,
  output logic                   done,
  output logic                   err,
  output logic [WORD_LENGTH-1:0] bus_out,
  output logic                   bus_valid,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [WORD_LENGTH-1:0] rd_data
);

  typedef enum logic [2:0] {IDLE, EXEC, SWAP1, SWAP2, SWAP3} state_t;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_MOVE  = 2'd1;
  localparam logic [1:0] OP_SWAP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  state_t                   state, state_nxt;
  logic [1:0]               op_q;
  logic [ADDR_W-1:0]        src_q, dst_q;
  logic [WORD_LENGTH-1:0]   data_q, tmp;
  logic [WORD_LENGTH-1:0]   regs [NUM_REGS];
  logic                     accept, illegal, we, bus_from_tmp;
  logic [ADDR_W-1:0]        waddr, bus_addr;
  logic [WORD_LENGTH-1:0]   bus_raw, wdata;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign illegal   = !in_range(dst_q) ||
                     (((op_q == OP_MOVE) || (op_q == OP_SWAP)) && !in_range(src_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Illegal commands still walk their states but never drive the bus or write.
  always_comb begin
    state_nxt    = state;
    bus_valid    = 1'b0;
    bus_addr     = src_q;
    bus_from_tmp = 1'b0;
    we           = 1'b0;
    waddr        = dst_q;
    case (state)
      IDLE: if (accept) state_nxt = (cmd_op == OP_SWAP) ? SWAP1 : EXEC;
      EXEC: begin
        state_nxt = IDLE;
        we        = !illegal;
        bus_valid = (op_q == OP_MOVE) && !illegal;
      end
      SWAP1: begin
        state_nxt = SWAP2;
        bus_valid = !illegal;
      end
      SWAP2: begin
        state_nxt = SWAP3;
        bus_valid = !illegal;
        bus_addr  = dst_q;
        we        = !illegal;
        waddr     = src_q;
      end
      SWAP3: begin
        state_nxt    = IDLE;
        bus_valid    = !illegal;
        bus_from_tmp = 1'b1;
        we           = !illegal;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_raw = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus_addr == ADDR_W'(i)) bus_raw = regs[i];
  end

  assign bus_out = bus_valid ? (bus_from_tmp ? tmp : bus_raw) : '0;
  assign wdata   = (state == EXEC && op_q == OP_LOAD)  ? data_q :
                   (state == EXEC && op_q == OP_CLEAR) ? '0     : bus_out;

  // Command fields are captured once at acceptance and held for the whole op.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= cmd_op;
      src_q  <= cmd_src;
      dst_q  <= cmd_dst;
      data_q <= cmd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      tmp <= '0;
    end else begin
      if (we)
        for (int i = 0; i < NUM_REGS; i++)
          if (waddr == ADDR_W'(i)) regs[i] <= wdata;
      if (state == SWAP1 && bus_valid) tmp <= bus_out;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= (state == EXEC) || (state == SWAP3);
      err  <= ((state == EXEC) || (state == SWAP3)) && illegal;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_addr == ADDR_W'(i)) rd_data = regs[i];
  end

endmodule

// File: tb/tb_reg_transfer_file.sv
// Randomised scoreboard bench for reg_transfer_file with a 3-entry file so that
// index 3 is an illegal address.
module tb_reg_transfer_file;
  localparam int W  = 8;
  localparam int NR = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready, done, err, bus_valid;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_src = '0, cmd_dst = '0, rd_addr = '0;
  logic [W-1:0]  cmd_data = '0, bus_out, rd_data;

  reg_transfer_file #(.WORD_LENGTH(W), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .done(done), .err(err), .bus_out(bus_out), .bus_valid(bus_valid),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic                 err;
    logic [1:0]           nbus;
    logic [2:0][W-1:0]    bus;
    logic [NR-1:0][W-1:0] regs;
    logic [31:0]          done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [W-1:0] model [NR];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Applies the command to the architectural model and queues what the DUT must show.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                       input logic [W-1:0] data);
    exp_t e;
    int n = 0;
    logic bad;
    logic [W-1:0] t;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    bad = (dst >= NR) || (((op == 2'd1) || (op == 2'd2)) && (src >= NR));
    e = '0;
    e.err = bad;
    e.done_cyc = cyc + ((op == 2'd2) ? 4 : 2);
    if (!bad) begin
      case (op)
        2'd0: model[dst] = data;
        2'd1: begin
          e.nbus = 2'd1;
          e.bus[0] = model[src];
          model[dst] = model[src];
        end
        2'd2: begin
          e.nbus = 2'd3;
          e.bus[0] = model[src];
          e.bus[1] = model[dst];
          e.bus[2] = model[src];
          t = model[src];
          model[src] = model[dst];
          model[dst] = t;
        end
        default: model[dst] = '0;
      endcase
    end
    for (int i = 0; i < NR; i++) e.regs[i] = model[i];
    sb_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_src = src;
    cmd_dst = dst;
    cmd_data = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
    cmd_src = AW'($urandom);
    cmd_dst = AW'($urandom);
    cmd_data = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sb_q.size(), 32'd0);
  endtask

  // Monitor: gathers bus traffic per command and checks everything on each done pulse.
  initial begin
    logic [W-1:0] cur[$];
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur.delete();
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_bus_out", {24'd0, bus_out}, 32'd0);
        for (int i = 0; i <= NR; i++) begin
          rd_addr = AW'(i);
          #1;
          chk("rst_reg", {24'd0, rd_data}, 32'd0);
        end
        continue;
      end
      if (!bus_valid) chk("undriven_bus_zero", {24'd0, bus_out}, 32'd0);
      else cur.push_back(bus_out);
      if (err && !done) chk("err_without_done", {31'd0, done}, 32'd1);
      if (done) begin
        if (sb_q.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("done_cycle", cyc, e.done_cyc);
          chk("ready_with_done", {31'd0, cmd_ready}, 32'd1);
          chk("bus_count", cur.size(), {30'd0, e.nbus});
          for (int k = 0; k < cur.size() && k < int'(e.nbus); k++)
            chk("bus_value", {24'd0, cur[k]}, {24'd0, e.bus[k]});
          for (int i = 0; i < NR; i++) begin
            rd_addr = AW'(i);
            #1;
            chk("reg", {24'd0, rd_data}, {24'd0, e.regs[i]});
          end
          rd_addr = AW'(NR);
          #1;
          chk("rd_out_of_range", {24'd0, rd_data}, 32'd0);
        end
        cur.delete();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);

    issue(2'd0, 2'd2, 2'd2, 8'hA5);
    issue(2'd0, 2'd0, 2'd0, 8'h3C);
    issue(2'd1, 2'd0, 2'd2, 8'h00);
    issue(2'd0, 2'd0, 2'd1, 8'h11);
    issue(2'd0, 2'd0, 2'd2, 8'h22);
    issue(2'd2, 2'd1, 2'd2, 8'h00);
    issue(2'd1, 2'd3, 2'd0, 8'h00);
    issue(2'd1, 2'd1, 2'd1, 8'h00);
    issue(2'd2, 2'd0, 2'd0, 8'h00);
    issue(2'd2, 2'd3, 2'd1, 8'h00);
    issue(2'd0, 2'd0, 2'd3, 8'h77);
    issue(2'd3, 2'd0, 2'd1, 8'h00);
    drain();

    // Abort a SWAP while it is in its second step.
    issue(2'd2, 2'd0, 2'd2, 8'h00);
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb_q.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    issue(2'd0, 2'd0, 2'd1, 8'hFF);
    drain();

    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(2'($urandom), AW'($urandom), AW'($urandom), W'($urandom));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
